// File: rtl/bullet_scheduler_if.sv
// Player-controller / bullet-state bundle for bullet_scheduler.
// The player side drives the requests; the scheduler drives the bullet state.
interface bullet_scheduler_if #(
  parameter int NUM_BULLETS = 4
);
  logic                       shoot;
  logic                       reload_req;
  logic [9:0]                 PlayerX;
  logic [9:0]                 PlayerY;
  logic [1:0]                 Direction;
  logic [10*NUM_BULLETS-1:0]  BulletX;
  logic [10*NUM_BULLETS-1:0]  BulletY;
  logic [2*NUM_BULLETS-1:0]   BulletDir;
  logic [NUM_BULLETS-1:0]     BulletActive;
  logic [3:0]                 Ammo;
  logic                       Reloading;
  logic                       Fire_Ack;

  modport master (
    output shoot, reload_req, PlayerX, PlayerY, Direction,
    input  BulletX, BulletY, BulletDir, BulletActive, Ammo, Reloading, Fire_Ack
  );

  modport slave (
    input  shoot, reload_req, PlayerX, PlayerY, Direction,
    output BulletX, BulletY, BulletDir, BulletActive, Ammo, Reloading, Fire_Ack
  );
endinterface

// File: rtl/bullet_scheduler.sv
// Per-frame projectile pool: spawns bullets at the player, moves live ones,
// retires them at the screen edge and runs the magazine/reload cycle.
module bullet_scheduler #(
  parameter int NUM_BULLETS   = 4,
  parameter int BULLET_STEP   = 4,
  parameter int MAG_SIZE      = 6,
  parameter int RELOAD_FRAMES = 30,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479
) (
  input  logic            Reset,
  input  logic            frame_clk,
  bullet_scheduler_if.slave bus
);

  localparam int               CNT_W    = $clog2(RELOAD_FRAMES + 1);
  localparam logic [3:0]       MAG_FULL = 4'(MAG_SIZE);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(RELOAD_FRAMES - 1);
  localparam logic [9:0]       X_LIM    = 10'(X_MAX);
  localparam logic [9:0]       Y_LIM    = 10'(Y_MAX);
  localparam logic signed [11:0] STEP_S = 12'(BULLET_STEP);

  typedef enum logic {READY, RELOADING} state_t;

  state_t                 state_q, state_d;
  logic [9:0]             x_q   [NUM_BULLETS];
  logic [9:0]             x_d   [NUM_BULLETS];
  logic [9:0]             y_q   [NUM_BULLETS];
  logic [9:0]             y_d   [NUM_BULLETS];
  logic [1:0]             dir_q [NUM_BULLETS];
  logic [1:0]             dir_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [NUM_BULLETS-1:0] alloc_oh;
  logic [3:0]             ammo_q, ammo_d, ammo_post;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic                   accept;
  logic                   free_seen;
  logic [10:0]            mv;

  // Returns {retire, next_coord}; signed 12-bit math so neither edge can wrap.
  function automatic logic [10:0] advance(input logic [9:0] pos,
                                          input logic       toward_zero,
                                          input logic [9:0] limit);
    logic signed [11:0] cur;
    logic signed [11:0] nxt;
    cur = $signed({2'b00, pos});
    nxt = toward_zero ? (cur - STEP_S) : (cur + STEP_S);
    advance = {(nxt < 12'sd0) || (nxt > $signed({2'b00, limit})), nxt[9:0]};
  endfunction

  // Lowest-index slot that was free before the edge; retiring slots don't count.
  always_comb begin
    free_seen = 1'b0;
    alloc_oh  = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      alloc_oh[i] = ~active_q[i] & ~free_seen;
      free_seen   = free_seen | ~active_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ammo_d   = ammo_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    ack_d    = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    mv       = '0;

    accept    = (state_q == READY) && bus.shoot && (ammo_q != 4'd0) && (|alloc_oh);
    ammo_post = accept ? (ammo_q - 4'd1) : ammo_q;

    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i]) begin
        // dir[1] selects the Y axis; left (0) and up (3) move toward zero
        mv = dir_q[i][1] ? advance(y_q[i], dir_q[i][0], Y_LIM)
                         : advance(x_q[i], ~dir_q[i][0], X_LIM);
        if (mv[10])          active_d[i] = 1'b0;
        else if (dir_q[i][1]) y_d[i]     = mv[9:0];
        else                  x_d[i]     = mv[9:0];
      end
      if (accept && alloc_oh[i]) begin
        x_d[i]      = bus.PlayerX;
        y_d[i]      = bus.PlayerY;
        dir_d[i]    = bus.Direction;
        active_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      READY: begin
        ammo_d = ammo_post;
        ack_d  = accept;
        if ((accept && ammo_post == 4'd0) || (bus.reload_req && ammo_post < MAG_FULL))
          state_d = RELOADING;
      end
      RELOADING: begin
        if (cnt_q == CNT_PEN) begin
          state_d = READY;
          cnt_d   = '0;
          ammo_d  = MAG_FULL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= READY;
      ammo_q   <= MAG_FULL;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      active_q <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ammo_q   <= ammo_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign bus.BulletX[10*g +: 10]  = x_q[g];
    assign bus.BulletY[10*g +: 10]  = y_q[g];
    assign bus.BulletDir[2*g +: 2]  = dir_q[g];
  end

  assign bus.BulletActive = active_q;
  assign bus.Ammo         = ammo_q;
  assign bus.Reloading    = (state_q == RELOADING);
  assign bus.Fire_Ack     = ack_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: a behavioural frame model predicts
// every edge, plus directed checks on the key scenarios.
module tb_bullet_scheduler;
  localparam int NB = 4;

  logic Reset;
  logic frame_clk;

  bullet_scheduler_if #(.NUM_BULLETS(NB)) bus();

  bullet_scheduler #(
    .NUM_BULLETS(NB), .BULLET_STEP(4), .MAG_SIZE(6),
    .RELOAD_FRAMES(30), .X_MAX(639), .Y_MAX(479)
  ) dut (
    .Reset(Reset),
    .frame_clk(frame_clk),
    .bus(bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [10*NB-1:0] bx;
    logic [10*NB-1:0] by;
    logic [2*NB-1:0]  bd;
    logic [NB-1:0]    act;
    logic [3:0]       ammo;
    logic             rel;
    logic             ack;
  } obs_t;

  obs_t sb_q[$];
  int   checks;
  int   failures;

  int mx[NB];
  int my[NB];
  int md[NB];
  bit ma[NB];
  int m_ammo;
  int m_cnt;
  bit m_rel;
  bit m_ack;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i] = 0; my[i] = 0; md[i] = 0; ma[i] = 0;
    end
    m_ammo = 6; m_cnt = 0; m_rel = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit sh, input bit rl, input int px, input int py, input int d);
    bit pre[NB];
    bit was_rel;
    bit took;
    was_rel = m_rel;
    took    = 0;
    pre     = ma;
    for (int i = 0; i < NB; i++) begin
      if (pre[i]) begin
        case (md[i])
          0: if (mx[i] < 4)        ma[i] = 0; else mx[i] -= 4;
          1: if (mx[i] + 4 > 639)  ma[i] = 0; else mx[i] += 4;
          2: if (my[i] + 4 > 479)  ma[i] = 0; else my[i] += 4;
          default: if (my[i] < 4)  ma[i] = 0; else my[i] -= 4;
        endcase
      end
    end
    if (!was_rel && sh && m_ammo > 0) begin
      for (int i = 0; i < NB; i++) begin
        if (!took && !pre[i]) begin
          mx[i] = px; my[i] = py; md[i] = d; ma[i] = 1; took = 1;
        end
      end
    end
    if (took) m_ammo--;
    m_ack = took;
    if (was_rel) begin
      m_cnt++;
      if (m_cnt == 30) begin
        m_rel = 0; m_cnt = 0; m_ammo = 6;
      end
    end else if ((took && m_ammo == 0) || (rl && m_ammo < 6)) begin
      m_rel = 1;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < NB; i++) begin
      o.bx[10*i +: 10] = 10'(mx[i]);
      o.by[10*i +: 10] = 10'(my[i]);
      o.bd[2*i +: 2]   = 2'(md[i]);
      o.act[i]         = ma[i];
    end
    o.ammo = 4'(m_ammo);
    o.rel  = m_rel;
    o.ack  = m_ack;
    return o;
  endfunction

  task automatic set_in(input bit sh, input bit rl, input int px, input int py, input int d);
    bus.shoot      = sh;
    bus.reload_req = rl;
    bus.PlayerX    = 10'(px);
    bus.PlayerY    = 10'(py);
    bus.Direction  = 2'(d);
  endtask

  task automatic step();
    obs_t e;
    model_edge(bus.shoot, bus.reload_req, int'(bus.PlayerX), int'(bus.PlayerY), int'(bus.Direction));
    sb_q.push_back(model_obs());
    @(posedge frame_clk);
    #1;
    check("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_act",  bus.BulletActive, e.act);
      check("sb_bx",   bus.BulletX, e.bx);
      check("sb_by",   bus.BulletY, e.by);
      check("sb_bd",   bus.BulletDir, e.bd);
      check("sb_ammo", bus.Ammo, e.ammo);
      check("sb_rel",  bus.Reloading, e.rel);
      check("sb_ack",  bus.Fire_Ack, e.ack);
    end
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    check({tag, "_act"},  bus.BulletActive, 0);
    check({tag, "_ammo"}, bus.Ammo, 6);
    check({tag, "_rel"},  bus.Reloading, 0);
    check({tag, "_ack"},  bus.Fire_Ack, 0);
    check({tag, "_bx"},   bus.BulletX, 0);
    check({tag, "_by"},   bus.BulletY, 0);
    check({tag, "_bd"},   bus.BulletDir, 0);
    Reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #12;
    do_reset("rst");

    // single shot, then first move
    set_in(1, 0, 320, 240, 1); step();
    check("t1_x0",   bus.BulletX[9:0], 320);
    check("t1_y0",   bus.BulletY[9:0], 240);
    check("t1_ammo", bus.Ammo, 5);
    check("t1_ack",  bus.Fire_Ack, 1);
    set_in(0, 0, 320, 240, 1); step();
    check("t1_move", bus.BulletX[9:0], 324);
    check("t1_ackf", bus.Fire_Ack, 0);

    // held shoot fills slots in order, fifth edge rejected
    do_reset("r2");
    set_in(1, 0, 100, 100, 2);
    repeat (5) step();
    check("t2_act",  bus.BulletActive, 4'hF);
    check("t2_ammo", bus.Ammo, 2);
    check("t2_ack",  bus.Fire_Ack, 0);

    // edge retirement on all four directions, then shoot+reload together
    do_reset("r3");
    set_in(1, 0, 2, 50, 0);   step();
    set_in(0, 0, 2, 50, 0);   step();
    check("t3_left_act", bus.BulletActive[0], 0);
    check("t3_left_x",   bus.BulletX[9:0], 2);
    set_in(1, 0, 636, 50, 1); step();
    set_in(0, 0, 636, 50, 1); step();
    check("t3_right_act", bus.BulletActive[0], 0);
    check("t3_right_x",   bus.BulletX[9:0], 636);
    set_in(1, 0, 10, 478, 2); step();
    set_in(1, 0, 10, 3, 3);   step();
    set_in(0, 0, 10, 3, 3);   step();
    check("t3_vert_act", bus.BulletActive, 0);
    set_in(1, 1, 300, 300, 1); step();
    check("t3_both_ammo", bus.Ammo, 1);
    check("t3_both_rel",  bus.Reloading, 1);

    // magazine exhaustion and full reload cycle with shoot held
    do_reset("r4");
    set_in(1, 0, 4, 100, 0);
    repeat (6) step();
    check("t4_rel",  bus.Reloading, 1);
    check("t4_ammo", bus.Ammo, 0);
    repeat (29) step();
    check("t4_rel_hold", bus.Reloading, 1);
    check("t4_ack_hold", bus.Fire_Ack, 0);
    step();
    check("t4_rel_done",  bus.Reloading, 0);
    check("t4_ammo_full", bus.Ammo, 6);
    step();
    check("t4_refire", bus.Fire_Ack, 1);

    // manual reload, reset in the middle of it
    do_reset("r5");
    set_in(0, 1, 0, 0, 0); step();
    check("t5_full_ign", bus.Reloading, 0);
    set_in(1, 0, 300, 200, 1);
    repeat (3) step();
    set_in(0, 1, 300, 200, 1); step();
    check("t5_rel",  bus.Reloading, 1);
    check("t5_ammo", bus.Ammo, 3);
    set_in(1, 1, 300, 200, 1);
    repeat (9) step();
    do_reset("t5_midrst");

    // retiring slot is not free on the same edge
    set_in(1, 0, 300, 100, 1); step(); step();
    set_in(1, 0, 4, 100, 0);   step();
    set_in(1, 0, 300, 100, 1); step(); step();
    check("t6_rej_act", bus.BulletActive, 4'b1011);
    check("t6_rej_ack", bus.Fire_Ack, 0);
    set_in(1, 0, 500, 120, 3); step();
    check("t6_acc_act",  bus.BulletActive, 4'hF);
    check("t6_acc_ack",  bus.Fire_Ack, 1);
    check("t6_acc_x2",   bus.BulletX[29:20], 500);
    check("t6_acc_d2",   bus.BulletDir[5:4], 3);
    check("t6_acc_ammo", bus.Ammo, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Manages the player's projectile pool. On each frame it samples the shoot and reload requests from the player controller, allocates a free bullet slot at the player's position and facing, and advances every live bullet by a fixed step. It retires bullets at the screen edge and enforces a magazine/reload cycle. It sits between the player movement block (source of PlayerX/PlayerY/Direction/shoot) and the color mapper / collision logic (consumers of bullet state).

## Interface
Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..8)
- BULLET_STEP, 4, pixels moved per frame by a live bullet
- MAG_SIZE, 6, rounds per magazine (1..15)
- RELOAD_FRAMES, 30, frames spent reloading (≥1)
- X_MAX, 639, rightmost legal X
- Y_MAX, 479, bottommost legal Y

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  clock, one edge per video frame
- shoot  in  1  fire request, sampled each edge; one shot per asserted edge
- reload_req  in  1  manual reload request, sampled each edge
- PlayerX, PlayerY  in  10 each  player position, unsigned
- Direction  in  2  player facing: 0=left, 1=right, 2=down (+Y), 3=up (−Y)
- BulletX, BulletY  out  10*NUM_BULLETS  slot i at bits [10i+9:10i]
- BulletDir  out  2*NUM_BULLETS  travel direction per slot, same encoding as Direction
- BulletActive  out  NUM_BULLETS  slot-live mask
- Ammo  out  4  rounds remaining
- Reloading  out  1  high while in RELOADING
- Fire_Ack  out  1  high for one frame after a shot is accepted

## Operation
- Reset values: BulletActive=0, BulletX/BulletY/BulletDir=0, Ammo=MAG_SIZE, Reloading=0, Fire_Ack=0, state=READY, reload counter=0.
- States: READY, RELOADING.
- READY: a shot is accepted when shoot=1, Ammo>0, and at least one slot is free in the pre-edge mask. Acceptance loads the lowest-index free slot with PlayerX, PlayerY, and Direction, sets it active, decrements Ammo, and sets Fire_Ack=1. Otherwise Fire_Ack=0 and nothing changes.
- READY → RELOADING when the accepted shot takes Ammo to 0, or when reload_req=1 with Ammo<MAG_SIZE. reload_req with a full magazine is ignored. If shoot and reload_req arrive on the same edge, shoot is evaluated first; reload then applies only if Ammo<MAG_SIZE after the shot.
- RELOADING: shoot and reload_req are ignored and Fire_Ack=0. The counter runs 1..RELOAD_FRAMES. On the edge that reaches RELOAD_FRAMES, Ammo=MAG_SIZE, the state returns to READY, and the counter clears.
- Bullet motion applies every edge, in both states, to each slot active before the edge.
  - Left: if X < BULLET_STEP, retire; else X−=BULLET_STEP.
  - Right: if X+BULLET_STEP > X_MAX, retire; else X+=BULLET_STEP.
  - Down and up follow the same rules against Y_MAX and 0.
- Arithmetic: compare in 11 bits so nothing wraps. A bullet never holds an off-screen coordinate.
- Retiring clears only the active bit. X, Y, and Dir hold their last values.
- A newly spawned bullet does not move on its spawn edge. It first moves on the next edge.
- Simultaneous retire and shoot: a slot retiring on this edge is not free for allocation on this edge.
- Reset mid-flight or mid-reload returns every output to its reset value immediately.

## Timing
- Single clock domain (frame_clk). All outputs are registered.
- Shot latency: shoot high at edge N gives BulletActive[i]=1, the spawn position, Ammo−1, and Fire_Ack=1 after edge N. Fire_Ack falls after edge N+1 unless a new shot is accepted.
- Reload: entered at edge E. Reloading=1 from E through E+RELOAD_FRAMES−1. At E+RELOAD_FRAMES, Ammo=MAG_SIZE and Reloading=0, and a shot is accepted at edge E+RELOAD_FRAMES+1 at the earliest.
- Holding shoot high fires once per edge until slots or ammo run out. No edge detection is done in this block.

## Test plan
- Reset, then shoot for one edge with PlayerX=320, PlayerY=240, Direction=1 → slot0 active at (320,240), Ammo=5, Fire_Ack=1. On the next edge X=324 and Fire_Ack=0.
- Hold shoot with NUM_BULLETS=4 and all bullets far from the edges → slots 0..3 fill in order and Ammo goes 6→2. The 5th edge gives no change and Fire_Ack=0.
- Bullet at X=2 with Direction=0 → next edge clears its active bit with X=2. At X=636 with Direction=1: if 636+4=640 > 639, retire.
- Fire 6 shots at 2 slots with bullets retiring in between → after the 6th, Reloading=1 and shoot is ignored for 30 edges. Then Ammo=6 and Reloading=0.
- reload_req at Ammo=6 → ignored. At Ammo=3 → RELOADING. Assert Reset at reload frame 10 → Ammo=6, Reloading=0, all slots inactive.
- All slots full, slot2 retires on the same edge as shoot → shot rejected (Fire_Ack=0). On the next edge shoot is accepted into slot2.
